alu_issue: RTL and testbench

Sequencing stage directly upstream of the 8-bit combinational ALU. It accepts instruction words over a valid/ready handshake and owns the accumulator. For each instruction it drives the ALU's `opcode`/`b`/`a` inputs, captures `y` back into the accumulator, and presents the result downstream over a second valid/ready handshake. It turns the stateless ALU into a one-instruction-at-a-time accumulator datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_issue_if.sv | 25 ++
 rtl/alu_issue.sv | 118 +++++++++++
 tb/tb_alu_issue.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue stage: opcodes, FSM states, instruction layout.
package alu_pkg;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned IMM_LSB = 0;

    // Opcode field sits directly above the immediate: in_instr[WIDTH+OPC_W-1:WIDTH].
    function automatic int unsigned opc_lsb(input int unsigned width);
        return width;
    endfunction

    localparam logic [OPC_W-1:0] OP_PLUS  = 3'd0;
    localparam logic [OPC_W-1:0] OP_MINUS = 3'd1;
    localparam logic [OPC_W-1:0] OP_AND   = 3'd2;
    localparam logic [OPC_W-1:0] OP_OR    = 3'd3;
    localparam logic [OPC_W-1:0] OP_NOT   = 3'd4;
    localparam logic [OPC_W-1:0] OP_LOAD  = 3'd5;
    localparam logic [OPC_W-1:0] OP_NOP   = 3'd6;
    localparam logic [OPC_W-1:0] OP_ILL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction-in and result-out handshakes of the ALU issue stage.
interface alu_issue_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH+OPC_W-1:0] in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_zero;
    logic                   out_err;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_err
    );
endinterface

// File: rtl/alu_issue.sv
// Accumulator sequencer in front of the combinational ALU: one instruction per IDLE/EXEC/RESP pass.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_if.slave       bus,
    output logic [OPC_W-1:0] alu_opcode,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_y
);

    localparam int unsigned OPC_LSB = opc_lsb(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [OPC_W-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_zero_q, out_zero_d;
    logic               out_err_q, out_err_d;

    // Next-state and datapath updates; everything holds unless the current state says otherwise.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // ALU operand registers load alongside op/imm so they are valid for the whole EXEC cycle.
                    op_d     = bus.in_instr[OPC_LSB +: OPC_W];
                    imm_d    = bus.in_instr[IMM_LSB +: WIDTH];
                    alu_op_d = bus.in_instr[OPC_LSB +: OPC_W];
                    alu_a_d  = bus.in_instr[IMM_LSB +: WIDTH];
                    alu_b_d  = acc_q;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_PLUS, OP_MINUS, OP_AND, OP_OR, OP_NOT: acc_d = alu_y;
                    OP_LOAD:                                  acc_d = imm_q;
                    default:                                  acc_d = acc_q;
                endcase
                out_data_d  = acc_d;
                out_zero_d  = (acc_d == '0);
                out_err_d   = (op_q == OP_ILL);
                out_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            op_q        <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b1;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_err   = out_err_q;
    assign alu_opcode    = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural 8-bit ALU beside it.
module tb_alu_issue;

    logic       clk;
    logic       rst_n;
    logic [2:0] alu_opcode;
    logic [7:0] alu_b;
    logic [7:0] alu_a;
    logic [7:0] alu_y;

    int n_checks;
    int n_fail;

    alu_issue_if #(.WIDTH(8)) bus ();

    alu_issue #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_b      (alu_b),
        .alu_a      (alu_a),
        .alu_y      (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: y = f(b, a), b carries the accumulator, a the immediate.
    always_comb begin
        case (alu_opcode)
            3'd0:    alu_y = alu_b + alu_a;
            3'd1:    alu_y = alu_b - alu_a;
            3'd2:    alu_y = alu_b & alu_a;
            3'd3:    alu_y = alu_b | alu_a;
            3'd4:    alu_y = ~alu_a;
            default: alu_y = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One instruction end to end; acc_before is the accumulator expected on alu_b during EXEC.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic [7:0] imm,
                             input logic [7:0] acc_before, input logic [7:0] exp_data,
                             input logic exp_zero, input logic exp_err, input int hold);
        @(negedge clk);
        bus.in_instr  = {op, imm};
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        check({tag, ".rdy_idle"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, ".exec_vld"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".exec_rdy"}, 32'(bus.in_ready), 32'd0);
        check({tag, ".alu_op"}, 32'(alu_opcode), 32'(op));
        check({tag, ".alu_a"}, 32'(alu_a), 32'(imm));
        check({tag, ".alu_b"}, 32'(alu_b), 32'(acc_before));
        @(negedge clk);
        check({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".data"}, 32'(bus.out_data), 32'(exp_data));
        check({tag, ".zero"}, 32'(bus.out_zero), 32'(exp_zero));
        check({tag, ".err"}, 32'(bus.out_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_vld"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_data"}, 32'(bus.out_data), 32'(exp_data));
            check({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".done_vld"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".done_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        check("rst.vld", 32'(bus.out_valid), 32'd0);
        check("rst.data", 32'(bus.out_data), 32'h00);
        check("rst.zero", 32'(bus.out_zero), 32'd1);
        check("rst.err", 32'(bus.out_err), 32'd0);
        check("rst.rdy", 32'(bus.in_ready), 32'd1);
        check("rst.alu_op", 32'(alu_opcode), 32'd0);
        check("rst.alu_a", 32'(alu_a), 32'd0);
        check("rst.alu_b", 32'(alu_b), 32'd0);
        rst_n = 1'b1;

        run_instr("load5",  3'd5, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 0);
        run_instr("plus3",  3'd0, 8'h03, 8'h05, 8'h08, 1'b0, 1'b0, 0);
        run_instr("load0",  3'd5, 8'h00, 8'h08, 8'h00, 1'b1, 1'b0, 0);
        run_instr("minus1", 3'd1, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 0);
        run_instr("plus1",  3'd0, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 0);
        run_instr("bp",     3'd5, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 5);
        run_instr("ill",    3'd7, 8'hAA, 8'h3C, 8'h3C, 1'b0, 1'b1, 0);
        run_instr("nop",    3'd6, 8'h55, 8'h3C, 8'h3C, 1'b0, 1'b0, 0);
        run_instr("and",    3'd2, 8'h0F, 8'h3C, 8'h0C, 1'b0, 1'b0, 0);
        run_instr("or",     3'd3, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 0);
        run_instr("not",    3'd4, 8'h0F, 8'hFC, 8'hF0, 1'b0, 1'b0, 0);

        // Reset during EXEC of PLUS 0x10: instruction is dropped.
        @(negedge clk);
        bus.in_instr = {3'd0, 8'h10};
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid.exec_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid.rst_rdy", 32'(bus.in_ready), 32'd1);
        check("mid.rst_alu_op", 32'(alu_opcode), 32'd0);
        check("mid.rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid.no_vld", 32'(bus.out_valid), 32'd0);
            check("mid.data", 32'(bus.out_data), 32'h00);
        end
        run_instr("post_plus0", 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0);
        run_instr("post_load1", 3'd5, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
